// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared width default and launcher state encoding for the TX feeder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    TXF_IDLE  = 2'd0,
    TXF_START = 2'd1,
    TXF_WAIT  = 2'd2
  } txf_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_tx_feeder_sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock byte FIFO with occupancy count and sticky overflow.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_Clock,
  input  logic              i_Rst,
  input  logic              i_Wr_En,
  input  logic [DATA_W-1:0] i_Wr_Data,
  input  logic              i_Rd_En,
  output logic [DATA_W-1:0] o_Rd_Data,
  output logic              o_Full,
  output logic              o_Empty,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Overflow,
  input  logic              i_Clr_Ovf
);

  localparam logic [ADDR_W:0] C_FULL = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              w_wr_acc;
  logic              w_rd_acc;

  assign o_Full     = (count_q == C_FULL);
  assign o_Empty    = (count_q == '0);
  assign o_Count    = count_q;
  assign o_Overflow = ovf_q;
  assign o_Rd_Data  = mem_q[rd_ptr_q];

  assign w_wr_acc = i_Wr_En && !o_Full;
  assign w_rd_acc = i_Rd_En && !o_Empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    // Power-of-two depth lets the pointers wrap by natural overflow.
    if (w_wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (w_rd_acc) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({w_wr_acc, w_rd_acc})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase
    if (i_Wr_En && o_Full) ovf_d = 1'b1;
    else if (i_Clr_Ovf)    ovf_d = 1'b0;
  end

  always_ff @(posedge i_Clock or posedge i_Rst) begin
    if (i_Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (w_wr_acc) mem_q[wr_ptr_q] <= i_Wr_Data;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_feeder.sv
// ============================================================================
// Module   : uart_tx_feeder
// Purpose  : Buffers bus-written bytes and launches them one at a time to uart_tx.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_Clock,
  input  logic              i_Rst,
  input  logic              i_Wr_En,
  input  logic [DATA_W-1:0] i_Wr_Data,
  output logic              o_Full,
  output logic              o_Empty,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Overflow,
  input  logic              i_Clr_Ovf,
  input  logic              i_Flow_Ok,
  output logic              o_TX_Start,
  output logic [DATA_W-1:0] o_TX_Byte,
  input  logic              i_TX_Done,
  output logic              o_Busy
);

  txf_state_t        state_q, state_d;
  logic              start_q, start_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic              w_pop;
  logic [DATA_W-1:0] w_rd_data;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .i_Clock    (i_Clock),
    .i_Rst      (i_Rst),
    .i_Wr_En    (i_Wr_En),
    .i_Wr_Data  (i_Wr_Data),
    .i_Rd_En    (w_pop),
    .o_Rd_Data  (w_rd_data),
    .o_Full     (o_Full),
    .o_Empty    (o_Empty),
    .o_Count    (o_Count),
    .o_Overflow (o_Overflow),
    .i_Clr_Ovf  (i_Clr_Ovf)
  );

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    byte_d  = byte_q;
    w_pop   = 1'b0;
    case (state_q)
      TXF_IDLE: begin
        if (!o_Empty && i_Flow_Ok) begin
          w_pop   = 1'b1;
          byte_d  = w_rd_data;
          start_d = 1'b1;
          state_d = TXF_START;
        end
      end
      TXF_START: state_d = TXF_WAIT;
      // Flow control is only sampled at launch; an in-flight byte always completes.
      TXF_WAIT: begin
        if (i_TX_Done) state_d = TXF_IDLE;
      end
      default: state_d = TXF_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= TXF_IDLE;
      start_q <= 1'b0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      byte_q  <= byte_d;
    end
  end

  assign o_TX_Start = start_q;
  assign o_TX_Byte  = byte_q;
  assign o_Busy     = (state_q != TXF_IDLE);

endmodule

`default_nettype wire
